// File: rtl/axi_packet_if.sv
// axi_packet_if: AXI4 write/read channel bundle for the axi_packet memory slave.
//   Write address : AWADDR, AWLEN, AWSIZE, AWVALID (to slave), AWREADY (from slave)
//   Write data    : WDATA, WVALID, WLAST (to slave), WREADY (from slave)
//   Write response: BRESP, BVALID (from slave), BREADY (to slave)
//   Read address  : ARADDR, ARLEN, ARSIZE, ARVALID (to slave), ARREADY (from slave)
//   Read data     : RDATA, RRESP, RLAST, RVALID (from slave), RREADY (to slave)
// Modports: master (drives requests), slave (drives responses).
interface axi_packet_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WLAST;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID,
        input  AWREADY,
        output WDATA, WVALID, WLAST,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID,
        output AWREADY,
        input  WDATA, WVALID, WLAST,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_packet.sv
// axi_packet: AXI4 memory-mapped slave backed by a MEMORY_DEPTH x DATA_WIDTH
// word-addressed memory. Independent write and read FSMs, one outstanding
// INCR burst per channel. Bursts crossing a 4 KB page or running past the end
// of memory complete normally but answer SLVERR, write nothing and read zeros.
// Ports:
//   ACLK    - clock, all state changes on the rising edge
//   ARESETn - asynchronous active-low reset (memory contents are kept)
//   bus     - axi_packet_if slave modport (AW, W, B, AR, R channels)
module axi_packet #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    axi_packet_if.slave bus
);
    localparam int unsigned EW    = ADDR_WIDTH + 9;
    localparam int unsigned IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // Error rule evaluated once per burst at the address handshake; widened so
    // (len+1)<<size and the page offset sum cannot overflow.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [7:0]            l,
                                       input logic [2:0]            s);
        logic [EW-1:0] page_off;
        logic [EW-1:0] bytes;
        logic [EW-1:0] words;
        page_off = EW'(a) & EW'(4095);
        bytes    = (EW'(l) + EW'(1)) << s;
        words    = (EW'(a) >> 2) + EW'(l) + EW'(1);
        return ((page_off + bytes) > EW'(4096)) || (words > EW'(MEMORY_DEPTH));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] beat_step(input logic [2:0] s);
        return ADDR_WIDTH'(1) << s;
    endfunction

    // Guards the array index; for the default geometry the error rule already
    // keeps every legal beat inside memory, this only protects odd parameterisations.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> 2) < ADDR_WIDTH'(MEMORY_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> 2);
    endfunction

    // WLAST is not used for termination; the beat count decides.
    logic unused_wlast;
    assign unused_wlast = bus.WLAST;

    // ---------------------------------------------------------------- write side
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [2:0]            w_size;
    logic                  w_err;
    logic                  mem_we;

    // WREADY is high throughout W_DATA, so WVALID alone marks an accepted beat.
    always_comb begin
        mem_we = 1'b0;
        if ((w_state == W_DATA) && bus.WVALID && !w_err && in_range(w_addr))
            mem_we = 1'b1;
    end

    // No reset: contents survive ARESETn. mem_we is gated by the reset-forced
    // FSM state, so an aborted burst stops writing immediately.
    always_ff @(posedge ACLK) begin
        if (mem_we)
            mem[word_index(w_addr)] <= bus.WDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_size      <= '0;
            w_err       <= 1'b0;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BRESP   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.AWREADY && bus.AWVALID) begin
                        w_addr      <= bus.AWADDR;
                        w_len       <= bus.AWLEN;
                        w_size      <= bus.AWSIZE;
                        w_err       <= burst_err(bus.AWADDR, bus.AWLEN, bus.AWSIZE);
                        w_cnt       <= '0;
                        bus.AWREADY <= 1'b0;
                        bus.WREADY  <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        bus.AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (bus.WVALID) begin
                        w_addr <= w_addr + beat_step(w_size);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            bus.WREADY <= 1'b0;
                            bus.BVALID <= 1'b1;
                            bus.BRESP  <= w_err ? 2'b10 : 2'b00;
                            w_state    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bus.BVALID  <= 1'b0;
                        bus.BRESP   <= '0;
                        bus.AWREADY <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------- read side
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;   // address of the beat to present next
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;    // index of the beat currently on RDATA
    logic [2:0]            r_size;
    logic                  r_err;
    logic                  ar_err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_word;

    // Beat 0 is read straight from the AR request so it appears on the
    // handshake edge; later beats use the stored next-beat address.
    always_comb begin
        ar_err  = burst_err(bus.ARADDR, bus.ARLEN, bus.ARSIZE);
        rd_addr = r_addr;
        rd_err  = r_err;
        if (r_state == R_IDLE) begin
            rd_addr = bus.ARADDR;
            rd_err  = ar_err;
        end
        rd_word = '0;
        if (!rd_err && in_range(rd_addr))
            rd_word = mem[word_index(rd_addr)];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_err       <= 1'b0;
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RLAST   <= 1'b0;
            bus.RRESP   <= '0;
            bus.RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.ARREADY && bus.ARVALID) begin
                        r_addr      <= bus.ARADDR + beat_step(bus.ARSIZE);
                        r_len       <= bus.ARLEN;
                        r_size      <= bus.ARSIZE;
                        r_err       <= ar_err;
                        r_cnt       <= '0;
                        bus.ARREADY <= 1'b0;
                        bus.RVALID  <= 1'b1;
                        bus.RLAST   <= (bus.ARLEN == 8'd0);
                        bus.RRESP   <= ar_err ? 2'b10 : 2'b00;
                        bus.RDATA   <= rd_word;
                        r_state     <= R_DATA;
                    end else begin
                        bus.ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        if (bus.RLAST) begin
                            bus.RVALID  <= 1'b0;
                            bus.RLAST   <= 1'b0;
                            bus.RRESP   <= '0;
                            bus.RDATA   <= '0;
                            bus.ARREADY <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            bus.RDATA <= rd_word;
                            bus.RLAST <= ((r_cnt + 8'd1) == r_len);
                            r_addr    <= r_addr + beat_step(r_size);
                            r_cnt     <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_packet.sv
// tb_axi_packet: self-checking bench for axi_packet. A plain array models the
// memory; expected responses come from the address/length/size error rule
// evaluated with integer arithmetic. Directed scenarios are followed by
// randomized bursts.
module tb_axi_packet;
    logic aclk;
    logic aresetn;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] model_mem [1024];

    axi_packet_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi_packet #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (16),
        .MEMORY_DEPTH(1024)
    ) dut (
        .ACLK   (aclk),
        .ARESETn(aresetn),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] all_outs();
        return {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY,
                bus.RVALID, bus.RLAST, bus.RRESP, bus.RDATA};
    endfunction

    function automatic bit model_err(input int unsigned addr, input int unsigned len,
                                     input int unsigned size);
        int unsigned nbytes;
        nbytes = (len + 1) * (1 << size);
        return ((addr % 4096) + nbytes > 4096) || ((addr / 4) + len + 1 > 1024);
    endfunction

    function automatic int unsigned beat_word(input int unsigned addr, input int unsigned i,
                                              input int unsigned size);
        return (((addr + i * (1 << size)) % 65536) / 4) % 1024;
    endfunction

    task automatic do_write(input int unsigned addr, input int unsigned len,
                            input int unsigned size, input int unsigned bready_wait,
                            input bit gaps, input int unsigned dbase);
        bit          e;
        logic [1:0]  exp_resp;
        logic [31:0] d;
        int          t;
        e        = model_err(addr, len, size);
        exp_resp = e ? 2'b10 : 2'b00;
        bus.AWADDR  = 16'(addr);
        bus.AWLEN   = 8'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < 50) begin
            step();
            t++;
        end
        check("aw_ready_seen", 64'(bus.AWREADY), 64'd1);
        step();
        bus.AWVALID = 1'b0;
        check("aw_accept", 64'({bus.AWREADY, bus.WREADY}), 64'b01);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.WVALID = 1'b0;
                step();
                check("w_gap_ready", 64'({bus.WREADY, bus.BVALID}), 64'b10);
            end
            d = (dbase != 0) ? 32'(dbase + i) : $urandom;
            bus.WDATA  = d;
            bus.WVALID = 1'b1;
            bus.WLAST  = (i == int'(len));
            step();
            if (!e) model_mem[beat_word(addr, i, size)] = d;
            if (i < int'(len))
                check("w_mid_ready", 64'({bus.WREADY, bus.BVALID}), 64'b10);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("w_done", 64'({bus.WREADY, bus.BVALID}), 64'b01);
        check("bresp", 64'(bus.BRESP), 64'(exp_resp));
        for (int k = 0; k < int'(bready_wait); k++) begin
            step();
            check("b_hold", 64'({bus.BVALID, bus.BRESP, bus.AWREADY}), 64'({1'b1, exp_resp, 1'b0}));
        end
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        check("b_done", 64'({bus.BVALID, bus.AWREADY}), 64'b01);
    endtask

    task automatic do_read(input int unsigned addr, input int unsigned len,
                           input int unsigned size, input int stall_beat,
                           input int unsigned stall_n);
        bit          e;
        logic [31:0] exp;
        int          t;
        e = model_err(addr, len, size);
        bus.ARADDR  = 16'(addr);
        bus.ARLEN   = 8'(len);
        bus.ARSIZE  = 3'(size);
        bus.ARVALID = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < 50) begin
            step();
            t++;
        end
        check("ar_ready_seen", 64'(bus.ARREADY), 64'd1);
        step();
        bus.ARVALID = 1'b0;
        check("ar_accept", 64'({bus.ARREADY, bus.RVALID}), 64'b01);
        for (int i = 0; i <= int'(len); i++) begin
            exp = e ? 32'd0 : model_mem[beat_word(addr, i, size)];
            check("rdata", 64'(bus.RDATA), 64'(exp));
            check("rresp", 64'(bus.RRESP), e ? 64'd2 : 64'd0);
            check("rlast", 64'(bus.RLAST), 64'(i == int'(len)));
            if (i == stall_beat) begin
                for (int k = 0; k < int'(stall_n); k++) begin
                    step();
                    check("r_hold", 64'({bus.RVALID, bus.RLAST, bus.RDATA}),
                          64'({1'b1, (i == int'(len)), exp}));
                end
            end
            bus.RREADY = 1'b1;
            step();
            bus.RREADY = 1'b0;
        end
        check("r_done", 64'({bus.RVALID, bus.RLAST, bus.ARREADY}), 64'b001);
    endtask

    initial begin
        int unsigned a, l, s;
        logic [31:0] d0, d1, d2;
        int          t;

        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        aresetn = 1'b0;

        // Reset state and release timing
        #2;
        check("reset_outputs", 64'(all_outs()), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("ready_before_edge", 64'({bus.AWREADY, bus.ARREADY}), 64'b00);
        step();
        check("ready_after_release", 64'({bus.AWREADY, bus.ARREADY}), 64'b11);

        // Fill the whole memory; the last burst ends exactly on the 4 KB / end boundary
        for (int k = 0; k < 4; k++)
            do_write(k * 1024, 255, 2, 0, 1'b0, 0);

        // Basic write / read-back
        do_write(32'h10, 3, 2, 0, 1'b0, 32'hA0);
        do_read(32'h10, 3, 2, -1, 0);
        check("word_0x10_const", 64'(model_mem[4]), 64'hA0);

        // 4 KB crossing write is rejected and leaves memory unchanged
        do_write(32'hFFC, 1, 2, 0, 1'b0, 0);
        do_read(32'hFFC, 0, 2, -1, 0);

        // Out-of-range read
        do_read(32'h1000, 2, 2, -1, 0);

        // Back-pressure on R and B
        do_read(32'h20, 5, 2, 2, 3);
        do_write(32'h30, 2, 2, 4, 1'b0, 0);

        // Reset during beat 2 of a 4-beat write
        bus.AWADDR = 16'h0300; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < 50) begin
            step();
            t++;
        end
        step();
        bus.AWVALID = 1'b0;
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        bus.WDATA = d0; bus.WVALID = 1'b1;
        step();
        model_mem[32'h300 / 4] = d0;
        bus.WDATA = d1;
        step();
        model_mem[32'h304 / 4] = d1;
        bus.WDATA = d2;
        #2;
        aresetn = 1'b0;
        #1;
        check("reset_mid_outputs", 64'(all_outs()), 64'd0);
        bus.WVALID = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("reset_held_outputs", 64'(all_outs()), 64'd0);
        aresetn = 1'b1;
        step();
        check("awready_after_abort", 64'(bus.AWREADY), 64'd1);
        do_write(32'h340, 3, 2, 0, 1'b0, 0);
        do_read(32'h300, 3, 2, -1, 0);

        // Concurrent write and read bursts
        fork
            do_write(32'h100, 7, 2, 1, 1'b1, 0);
            do_read(32'h200, 7, 2, 3, 2);
        join
        do_read(32'h100, 7, 2, -1, 0);

        // Randomized bursts, biased toward the 4 KB / end-of-memory edge
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 32'h10FF)
                                             : 32'hFC0 + $urandom_range(0, 32'h50);
            l = $urandom_range(0, 15);
            s = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(a, l, s, $urandom_range(0, 2), 1'b1, 0);
            else
                do_read(a, l, s, int'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
